karat_mult_sequencer: RTL and testbench

- Word-serial front/back end for the Karatsuba multiplier.
- Input side: receives two INPUT_SIZE-bit operands as a stream of WORD_WIDTH-bit words and holds them stable on the multiplier inputs.
- Control: drives the multiplier's enable and waits for its finish flag.
- Output side: captures the 2·INPUT_SIZE-bit product and streams it out as words.
- Sits between the key-schedule/bus interface and the multiplier core; the multiplier itself is a sibling instance outside this block.

---
 rtl/mult_seq_pkg.sv | 23 ++
 rtl/mult_result_serializer.sv | 53 +++++
 rtl/karat_mult_sequencer.sv | 157 +++++++++++++++
 tb/tb_karat_mult_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and sizing helpers for the Karatsuba multiplier word-serial sequencer.
package mult_seq_pkg;

    localparam int DEFAULT_WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        CLEAR,
        RUN,
        DRAIN
    } seq_state_t;

    function automatic int calc_wpo(input int input_size, input int word_width);
        return input_size / word_width;
    endfunction

    // One counter width serves both the operand and the product streams.
    function automatic int calc_cnt_width(input int wpo);
        return (2 * wpo > 1) ? $clog2(2 * wpo) : 1;
    endfunction

endpackage

// File: rtl/mult_result_serializer.sv
// Loadable product shift register that streams the product out least significant word first,
// with a valid/ready/last output port.
module mult_result_serializer
    import mult_seq_pkg::*;
#(
    parameter int INPUT_SIZE = 1024,
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_srst,
    input  logic                    i_load,
    input  logic [2*INPUT_SIZE-1:0] i_result,
    output logic [WORD_WIDTH-1:0]   o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_last
);

    localparam int WPO    = calc_wpo(INPUT_SIZE, WORD_WIDTH);
    localparam int CNT_W  = calc_cnt_width(WPO);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(2 * WPO - 1);

    logic [2*INPUT_SIZE-1:0] r_shift;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_valid;
    logic                    w_xfer;

    assign w_xfer  = r_valid && i_ready;
    assign o_data  = r_shift[WORD_WIDTH-1:0];
    assign o_valid = r_valid;
    assign o_last  = r_valid && (r_cnt == LAST_IDX);

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_result;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_shift <= r_shift >> WORD_WIDTH;
            if (r_cnt == LAST_IDX) begin
                r_cnt   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/karat_mult_sequencer.sv
// Word-serial front/back end for the Karatsuba multiplier: collects operands, runs the core,
// streams the product. Define MULT_SEQ_TIMEOUT_EN to build the RUN-state watchdog.
module karat_mult_sequencer
    import mult_seq_pkg::*;
#(
    parameter int INPUT_SIZE     = 1024,
    parameter int WORD_WIDTH     = DEFAULT_WORD_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [WORD_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [WORD_WIDTH-1:0]   m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [INPUT_SIZE-1:0]   mult_in_1,
    output logic [INPUT_SIZE-1:0]   mult_in_2,
    output logic                    mult_enable,
    input  logic [2*INPUT_SIZE-1:0] mult_result,
    input  logic                    mult_finish,
    output logic                    busy,
    output logic                    error
);

    localparam int WPO   = calc_wpo(INPUT_SIZE, WORD_WIDTH);
    localparam int CNT_W = calc_cnt_width(WPO);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WPO - 1);

    seq_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_word_cnt, w_word_cnt_next;
    logic             r_mult_enable, w_mult_enable_next;
    logic             w_s_ready, w_s_xfer;
    logic             w_load_result, w_drain_done, w_timeout;

    assign w_s_ready     = !rst_in && ((r_state == LOAD_A) || (r_state == LOAD_B));
    assign w_s_xfer      = s_valid && w_s_ready;
    assign w_load_result = (r_state == RUN) && mult_finish;
    assign w_drain_done  = (r_state == DRAIN) && m_valid && m_ready && m_last;

    assign s_ready     = w_s_ready;
    assign mult_enable = r_mult_enable;
    assign busy        = (r_state != LOAD_A);

    // Operand words are held in their own registers so the core sees stable inputs until DRAIN.
    for (genvar gi = 0; gi < WPO; gi++) begin : g_op_word
        logic [WORD_WIDTH-1:0] r_word_a, r_word_b;

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                r_word_a <= '0;
                r_word_b <= '0;
            end else if (w_s_xfer && (r_word_cnt == CNT_W'(gi))) begin
                if (r_state == LOAD_A) r_word_a <= s_data;
                if (r_state == LOAD_B) r_word_b <= s_data;
            end
        end

        assign mult_in_1[gi*WORD_WIDTH +: WORD_WIDTH] = r_word_a;
        assign mult_in_2[gi*WORD_WIDTH +: WORD_WIDTH] = r_word_b;
    end

`ifdef MULT_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_error;

    assign w_timeout = (r_state == RUN) && !mult_finish &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign error     = r_error;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tmo_cnt <= '0;
            r_error   <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == RUN) ? r_tmo_cnt + 1'b1 : '0;
            if (w_timeout)
                r_error <= 1'b1;
            else if (w_s_xfer)
                r_error <= 1'b0;
        end
    end
`else
    // Constant 0 for any legal TIMEOUT_CYCLES; no watchdog hardware is built.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
    assign error     = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= LOAD_A;
            r_word_cnt    <= '0;
            r_mult_enable <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_word_cnt    <= w_word_cnt_next;
            r_mult_enable <= w_mult_enable_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_word_cnt_next    = r_word_cnt;
        w_mult_enable_next = 1'b0;
        unique case (r_state)
            LOAD_A, LOAD_B: begin
                if (w_s_xfer) begin
                    if (r_word_cnt == WORD_LAST) begin
                        w_word_cnt_next = '0;
                        w_state_next    = (r_state == LOAD_A) ? LOAD_B : CLEAR;
                    end else begin
                        w_word_cnt_next = r_word_cnt + 1'b1;
                    end
                end
            end
            // A finish still high from the previous job must be seen low before enabling.
            CLEAR: begin
                if (!mult_finish) begin
                    w_state_next       = RUN;
                    w_mult_enable_next = 1'b1;
                end
            end
            RUN: begin
                if (mult_finish)
                    w_state_next = DRAIN;
                else if (w_timeout)
                    w_state_next = LOAD_A;
                else
                    w_mult_enable_next = 1'b1;
            end
            DRAIN: begin
                if (w_drain_done)
                    w_state_next = LOAD_A;
            end
            default: w_state_next = LOAD_A;
        endcase
    end

    mult_result_serializer #(
        .INPUT_SIZE (INPUT_SIZE),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_serializer (
        .i_clk    (clk_in),
        .i_srst   (rst_in),
        .i_load   (w_load_result),
        .i_result (mult_result),
        .o_data   (m_data),
        .o_valid  (m_valid),
        .i_ready  (m_ready),
        .o_last   (m_last)
    );

endmodule

// File: tb/tb_karat_mult_sequencer.sv
// Self-checking bench for karat_mult_sequencer with a behavioural multiplier (finish latency 3)
// and a product-word scoreboard. The watchdog test runs only with MULT_SEQ_TIMEOUT_EN.
module tb_karat_mult_sequencer;

    localparam int IS = 64;
    localparam int WW = 32;

    typedef struct {
        logic [WW-1:0] data;
        logic          last;
    } exp_t;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [WW-1:0]   s_data;
    logic            s_valid;
    logic            s_ready;
    logic [WW-1:0]   m_data;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;
    logic [IS-1:0]   mult_in_1;
    logic [IS-1:0]   mult_in_2;
    logic            mult_enable;
    logic [2*IS-1:0] mult_result;
    logic            mult_finish;
    logic            busy;
    logic            error;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   stale_hold = 0;
    bit   never_finish = 1'b0;
    bit   toggle_ready = 1'b0;
    int   out_idx = 0;

    always #5 clk_in = ~clk_in;

    karat_mult_sequencer #(
        .INPUT_SIZE     (IS),
        .WORD_WIDTH     (WW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .mult_in_1   (mult_in_1),
        .mult_in_2   (mult_in_2),
        .mult_enable (mult_enable),
        .mult_result (mult_result),
        .mult_finish (mult_finish),
        .busy        (busy),
        .error       (error)
    );

    // Behavioural multiplier: finish rises 3 cycles after enable, falls stale_hold cycles after enable drops.
    int lat_cnt, hold_cnt;
    always @(posedge clk_in) begin
        if (rst_in) begin
            mult_finish <= 1'b0;
            mult_result <= '0;
            lat_cnt     <= 0;
            hold_cnt    <= 0;
        end else if (mult_enable) begin
            hold_cnt <= 0;
            if (!mult_finish && !never_finish) begin
                if (lat_cnt == 2) begin
                    mult_finish <= 1'b1;
                    mult_result <= {{IS{1'b0}}, mult_in_1} * {{IS{1'b0}}, mult_in_2};
                    lat_cnt     <= 0;
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end else begin
            lat_cnt <= 0;
            if (mult_finish) begin
                if (hold_cnt >= stale_hold) begin
                    mult_finish <= 1'b0;
                    hold_cnt    <= 0;
                end else begin
                    hold_cnt <= hold_cnt + 1;
                end
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk_in); #1;
            m_ready = toggle_ready ? ~m_ready : 1'b1;
        end
    end

    // Output scoreboard and stall-stability monitor, sampled mid-cycle.
    logic          stalled = 1'b0;
    logic [WW-1:0] stall_data;
    exp_t          exp_w;
    always @(negedge clk_in) begin
        if (rst_in) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== stall_data) begin
                    errors++;
                    $display("FAIL m_stall_stable: got valid=%0b data=%08h, expected valid=1 data=%08h",
                             m_valid, m_data, stall_data);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL m_unexpected: got data=%08h last=%0b, expected no word", m_data, m_last);
                end else begin
                    exp_w = exp_q.pop_front();
                    $display("  out word %0d data=%08h last=%0b", out_idx, m_data, m_last);
                    if (m_data !== exp_w.data || m_last !== exp_w.last) begin
                        errors++;
                        $display("FAIL m_word: got data=%08h last=%0b, expected data=%08h last=%0b",
                                 m_data, m_last, exp_w.data, exp_w.last);
                    end
                end
                out_idx = exp_w.last ? 0 : out_idx + 1;
                stalled = 1'b0;
            end else begin
                stalled    = (m_valid === 1'b1);
                stall_data = m_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected end of tests");
        $fatal(1);
    end

    task automatic push_product(input logic [2*IS-1:0] p);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.data = p[i*WW +: WW];
            e.last = (i == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [WW-1:0] w, input int max_gap);
        bit got;
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin @(posedge clk_in); #1; end
        s_data  = w;
        s_valid = 1'b1;
        got     = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk_in);
            got = (s_ready === 1'b1);
            @(posedge clk_in); #1;
        end
        s_valid = 1'b0;
        $display("  in  word data=%08h", w);
        if (!got) begin
            checks++; errors++;
            $display("FAIL s_handshake: got no s_ready in 100 cycles, expected accept");
        end
    endtask

    task automatic send_job(input logic [IS-1:0] a, input logic [IS-1:0] b, input int max_gap);
        send_word(a[31:0], max_gap);
        send_word(a[63:32], max_gap);
        send_word(b[31:0], max_gap);
        send_word(b[63:32], max_gap);
    endtask

    task automatic wait_drained();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk_in); #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_enable(input bit level);
        int t;
        t = 0;
        while (mult_enable !== level && t < 50) begin
            @(posedge clk_in); #1;
            t++;
        end
        checks++;
        if (mult_enable !== level) begin
            errors++;
            $display("FAIL wait_enable: got mult_enable=%0b, expected %0b", mult_enable, level);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (3) begin
            @(posedge clk_in); #1;
            checks++;
            if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0b expected 0", s_ready); end
        end
        checks += 8;
        if (m_valid !== 1'b0)     begin errors++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
        if (m_last !== 1'b0)      begin errors++; $display("FAIL reset_m_last: got %0b expected 0", m_last); end
        if (mult_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %0b expected 0", mult_enable); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        if (error !== 1'b0)       begin errors++; $display("FAIL reset_error: got %0b expected 0", error); end
        if (m_data !== '0)        begin errors++; $display("FAIL reset_m_data: got %08h expected 0", m_data); end
        if (mult_in_1 !== '0)     begin errors++; $display("FAIL reset_in_1: got %016h expected 0", mult_in_1); end
        if (mult_in_2 !== '0)     begin errors++; $display("FAIL reset_in_2: got %016h expected 0", mult_in_2); end
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: got %0b expected 1", s_ready); end
    endtask

    task automatic test_small();
        int t;
        push_product(128'h0000000F);
        send_job(64'h3, 64'h5, 0);
        checks += 2;
        if (busy !== 1'b1)    begin errors++; $display("FAIL small_busy: got %0b expected 1", busy); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL small_clear_s_ready: got %0b expected 0", s_ready); end
        wait_enable(1'b1);
        checks += 3;
        if (mult_in_1 !== 64'h3) begin errors++; $display("FAIL small_in_1: got %016h expected 3", mult_in_1); end
        if (mult_in_2 !== 64'h5) begin errors++; $display("FAIL small_in_2: got %016h expected 5", mult_in_2); end
        if (s_ready !== 1'b0)    begin errors++; $display("FAIL small_run_s_ready: got %0b expected 0", s_ready); end
        t = 0;
        while (mult_finish !== 1'b1 && t < 20) begin @(posedge clk_in); #1; t++; end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL small_early_valid: got %0b expected 0", m_valid); end
        @(posedge clk_in); #1;
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL small_first_valid: got %0b expected 1", m_valid); end
        wait_drained();
        checks += 2;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL small_b2b_s_ready: got %0b expected 1", s_ready); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL small_idle_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_all_ones();
        push_product({32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000, 32'h00000001});
        send_job(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 0);
        wait_drained();
    endtask

    task automatic test_backpressure();
        logic [IS-1:0] a, b;
        toggle_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            push_product({{IS{1'b0}}, a} * {{IS{1'b0}}, b});
            send_job(a, b, 3);
            wait_drained();
        end
        toggle_ready = 1'b0;
        @(posedge clk_in); #1;
    endtask

    task automatic test_stale_finish();
        logic [IS-1:0] a, b;
        int stall;
        // Held long enough that the next job reaches CLEAR while finish is still high.
        stale_hold = 12;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        push_product({{IS{1'b0}}, a} * {{IS{1'b0}}, b});
        send_job(a, b, 0);
        wait_drained();
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        push_product({{IS{1'b0}}, a} * {{IS{1'b0}}, b});
        send_job(a, b, 0);
        stall = 0;
        while (mult_finish === 1'b1 && stall < 60) begin
            checks++;
            if (mult_enable !== 1'b0) begin errors++; $display("FAIL stale_enable: got %0b expected 0", mult_enable); end
            stall++;
            @(posedge clk_in); #1;
        end
        checks++;
        if (stall == 0 || stall >= 60) begin
            errors++;
            $display("FAIL stale_window: got %0d stale cycles, expected 1..59", stall);
        end
        stale_hold = 0;
        wait_drained();
    endtask

    task automatic test_reset_drain();
        logic [IS-1:0] a, b;
        int t;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        push_product({{IS{1'b0}}, a} * {{IS{1'b0}}, b});
        send_job(a, b, 0);
        t = 0;
        while (exp_q.size() > 2 && t < 50) begin @(posedge clk_in); #1; t++; end
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        checks += 3;
        if (m_valid !== 1'b0)     begin errors++; $display("FAIL rst_drain_m_valid: got %0b expected 0", m_valid); end
        if (mult_enable !== 1'b0) begin errors++; $display("FAIL rst_drain_enable: got %0b expected 0", mult_enable); end
        if (s_ready !== 1'b0)     begin errors++; $display("FAIL rst_drain_s_ready: got %0b expected 0", s_ready); end
        exp_q.delete();
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_drain_release: got %0b expected 1", s_ready); end
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        push_product({{IS{1'b0}}, a} * {{IS{1'b0}}, b});
        send_job(a, b, 0);
        wait_drained();
    endtask

    task automatic test_reset_run();
        send_job({$urandom, $urandom}, {$urandom, $urandom}, 0);
        wait_enable(1'b1);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        checks += 2;
        if (mult_enable !== 1'b0) begin errors++; $display("FAIL rst_run_enable: got %0b expected 0", mult_enable); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL rst_run_busy: got %0b expected 0", busy); end
        rst_in = 1'b0;
        @(posedge clk_in); #1;
    endtask

`ifdef MULT_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [IS-1:0] a, b;
        never_finish = 1'b1;
        send_job({$urandom, $urandom}, {$urandom, $urandom}, 0);
        wait_enable(1'b1);
        repeat (7) begin @(posedge clk_in); #1; end
        checks += 2;
        if (error !== 1'b0)       begin errors++; $display("FAIL tmo_early_error: got %0b expected 0", error); end
        if (mult_enable !== 1'b1) begin errors++; $display("FAIL tmo_early_enable: got %0b expected 1", mult_enable); end
        @(posedge clk_in); #1;
        checks += 4;
        if (error !== 1'b1)       begin errors++; $display("FAIL tmo_error: got %0b expected 1", error); end
        if (mult_enable !== 1'b0) begin errors++; $display("FAIL tmo_enable: got %0b expected 0", mult_enable); end
        if (s_ready !== 1'b1)     begin errors++; $display("FAIL tmo_s_ready: got %0b expected 1", s_ready); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL tmo_busy: got %0b expected 0", busy); end
        never_finish = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        push_product({{IS{1'b0}}, a} * {{IS{1'b0}}, b});
        send_word(a[31:0], 0);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL tmo_error_clear: got %0b expected 0", error); end
        send_word(a[63:32], 0);
        send_word(b[31:0], 0);
        send_word(b[63:32], 0);
        wait_drained();
    endtask
`endif

    initial begin
        test_reset();
        test_small();
        test_all_ones();
        test_backpressure();
        test_stale_finish();
        test_reset_drain();
        test_reset_run();
`ifdef MULT_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
